cu_fsm_mc: RTL and testbench
============================

// Module: cu_fsm_mc
// PURPOSE
//  Next-generation mycpu control unit. Decodes ins_in[15:9] (opcode_t) and z/n flags into datapath control words,
//  as the single-cycle CU does, and adds: memory wait-state handshake on fetch/LD/ST,
//  multi-cycle MUL, a bounded XXL shift loop, and a sticky error state on timeout.
//  Sits between the instruction register/flags and the datapath/memory interface.
// PARAMETERS
//  MUL_LAT    3   EX cycles for MUL (1 = single-cycle, identical to ADD timing)
//  WAIT_MAX   15  max consecutive cycles without mem_rdy_in before ERR
//  XL_MAX     16  max XXL shift iterations before ERR
//  RA_W       3   register address width; rs_out = 3 x {ovr, addr[RA_W-1:0]}
// PORTS
//  clk         in   1          clock
//  rst_n       in   1          synchronous active-low reset
//  ins_in      in   16         instruction; [15:9] opcode_t
//  z_in        in   1          zero flag
//  n_in        in   1          negative flag
//  mem_rdy_in  in   1          memory/IO access completes this cycle
//  ps_out      out  2          PC op: 00 hold, 01 inc, 10 branch, 11 jump
//  il_out      out  1          IR load
//  rw_out      out  1          register file write
//  rs_out      out  3*(RA_W+1) register select overrides (always 0 in this revision)
//  mm_out      out  1          memory address mux (1 = PC)
//  md_out      out  2          writeback mux: 00 FU, 01 mem, 10 IO
//  mb_out      out  1          B mux (1 = immediate)
//  fs_out      out  4          FU select
//  wen_out     out  1          memory write enable, active-low
//  iom_out     out  1          IO space select
//  mem_req_out out  1          memory/IO access request
//  halted_out  out  1          state == HLT
//  err_out     out  1          state == ERR
// BEHAVIOUR
//  - State register only; outputs Mealy-combinational from state, opcode, flags, mem_rdy_in.
//  - States (cu_state_t): RST, INF, EX0, MW, XL0, HLT, ERR.
//  - Default output word: ps=00, il=0, rw=0, rs=0, mm=0, md=00, mb=0, fs=0000, wen=1, iom=0, mem_req=0.
//  - rst_n=0 at a clock edge: state<=RST, wait/mul/xl counters<=0, regardless of state. Reset mid-wait/mid-MUL aborts the operation.
//  - Outputs while in RST: default word. RST -> INF unconditionally.
//  - INF: mm=1, mem_req=1. With mem_rdy=1: il=1, next EX0, wait_cnt<=0. With mem_rdy=0: il=0, stay, wait_cnt++.
//  - EX0, ALU ops MOVA..CLR: ps=01, rw=1, md=00, fs = opcode table code (MOVA 0000 ... CLR 1111),
//    mb=0 for two-operand ops. LDI: mb=1, fs=1100. ADI: mb=1, fs=0010. Next state INF.
//  - EX0 MUL: MUL_LAT=1 -> as ALU op. Otherwise fs=0011, ps=00, rw=0, mul_cnt<=1, next MW.
//    MW: fs=0011; if mul_cnt==MUL_LAT-1: rw=1, ps=01, next INF; else mul_cnt++.
//  - EX0 LD/ST/IOR/IOW: mm=0, mem_req=1. iom=1 for IOR/IOW. ST/IOW: wen=0, mb=0 held for the whole wait.
//    LD: md=01. IOR: md=10.
//    mem_rdy=1 -> ps=01, rw=1 for LD/IOR only, next INF. mem_rdy=0 -> ps=00, rw=0, stay EX0, wait_cnt++.
//  - BRZ/BRN: ps=10 if flag=1 else 01. JMP: ps=11. fs=0000, rw=0. Next INF.
//  - XXL: z=1 -> ps=01, next INF, xl_cnt<=0.
//    z=0 -> fs=1110, rw=1, ps=00, xl_cnt++, next XL0. XL0: default word, next EX0 (re-test z, no refetch).
//  - HAL -> HLT. HLT is absorbing until reset; halted_out=1; default word.
//  - Timeouts: wait_cnt reaching WAIT_MAX with mem_rdy=0 -> ERR (no il/rw/ps). xl_cnt reaching XL_MAX -> ERR.
//    ERR is absorbing until reset; err_out=1; default word. HAL wins over nothing (single opcode).
//  - Undefined opcode in EX0 -> ERR.
//  - Counters are saturating and cleared on every INF->EX0 and EX0->INF transition.
//    Widths: $clog2(max+1).
// STRUCTURE
//  - mycpu_pkg: cu_state_t extended with MW, ERR.
//  - mycpu_pkg: opcode_t (unchanged); localparam FS_* codes; localparam cu_ctrl_t default word (packed struct).
//  - One sub-module, cu_sat_counter (clear, inc, max, hit flag), instantiated for wait, mul and xl counts.
// TESTING
//  - Reset: rst_n=0 two cycles in EX0/MW -> state RST, ps=00, wen=1, il=0; next cycle INF with mm=1.
//  - Fetch wait: mem_rdy=0 for 3 cycles then 1 -> il=1 only on the 4th cycle; ps=00 throughout.
//  - MUL, MUL_LAT=3: EX0 + 2 MW cycles, fs=0011 each; rw=1, ps=01 only on the third cycle.
//  - ST with mem_rdy low 2 cycles: wen=0, mem_req=1 for 3 cycles; ps=01 on the 3rd; rw never 1.
//  - BRZ z=1 -> ps=10; BRN n=0 -> ps=01; JMP -> ps=11; HAL -> halted_out=1, held 10 cycles.
//  - Timeout, WAIT_MAX=15: mem_rdy=0 for 15 cycles in INF -> err_out=1, stays until rst_n=0.
//    XXL with z=0 for XL_MAX iterations -> err_out=1.

Source files
------------

// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared types and control-word constants for the mycpu control unit
package mycpu_pkg;

    typedef enum logic [2:0] {RST, INF, EX0, MW, XL0, HLT, ERR} cu_state_t;

    typedef enum logic [6:0] {
        OP_MOVA = 7'h00, OP_INC, OP_ADD, OP_ADDC, OP_SUB, OP_DEC, OP_AND, OP_OR,
        OP_XOR, OP_NOT, OP_NEG, OP_ASR, OP_MOVB, OP_SHR, OP_SHL, OP_CLR,
        OP_LDI = 7'h10, OP_ADI, OP_LD, OP_ST, OP_IOR, OP_IOW,
        OP_BRZ, OP_BRN, OP_JMP, OP_MUL, OP_XXL, OP_HAL
    } opcode_t;

    localparam logic [3:0] FS_MOVA = 4'b0000;
    localparam logic [3:0] FS_ADD  = 4'b0010;
    localparam logic [3:0] FS_MUL  = 4'b0011;
    localparam logic [3:0] FS_MOVB = 4'b1100;
    localparam logic [3:0] FS_SHL  = 4'b1110;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_BR   = 2'b10;
    localparam logic [1:0] PS_JMP  = 2'b11;

    localparam logic [1:0] MD_FU  = 2'b00;
    localparam logic [1:0] MD_MEM = 2'b01;
    localparam logic [1:0] MD_IO  = 2'b10;

    typedef struct packed {
        logic [1:0] ps;
        logic       il;
        logic       rw;
        logic       mm;
        logic [1:0] md;
        logic       mb;
        logic [3:0] fs;
        logic       wen;
        logic       iom;
        logic       mem_req;
    } cu_ctrl_t;

    localparam cu_ctrl_t CTRL_DEFAULT = '{
        ps: PS_HOLD, il: 1'b0, rw: 1'b0, mm: 1'b0, md: MD_FU, mb: 1'b0,
        fs: FS_MOVA, wen: 1'b1, iom: 1'b0, mem_req: 1'b0
    };

endpackage

// File: rtl/cu_sat_counter.sv
// rtl/cu_sat_counter.sv - saturating event counter flagging the increment that reaches MAX
module cu_sat_counter #(
    parameter int MAX = 15,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

    // hit marks the cycle whose increment brings the count to MAX
    assign hit = inc && (cnt == W'(MAX - 1));

endmodule

// File: rtl/cu_fsm_mc.sv
// rtl/cu_fsm_mc.sv - multi-cycle control unit with memory wait, MUL, XXL loop and error trap
module cu_fsm_mc
    import mycpu_pkg::*;
#(
    parameter int MUL_LAT  = 3,
    parameter int WAIT_MAX = 15,
    parameter int XL_MAX   = 16,
    parameter int RA_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           ins_in,
    input  logic                  z_in,
    input  logic                  n_in,
    input  logic                  mem_rdy_in,
    output logic [1:0]            ps_out,
    output logic                  il_out,
    output logic                  rw_out,
    output logic [3*(RA_W+1)-1:0] rs_out,
    output logic                  mm_out,
    output logic [1:0]            md_out,
    output logic                  mb_out,
    output logic [3:0]            fs_out,
    output logic                  wen_out,
    output logic                  iom_out,
    output logic                  mem_req_out,
    output logic                  halted_out,
    output logic                  err_out
);
    cu_state_t  state, next_state;
    cu_ctrl_t   ctrl;
    logic [6:0] opc;
    logic       is_load, is_store, is_io;
    logic       wait_inc, wait_hit, mul_inc, mul_hit, xl_inc, xl_hit, cnt_clr;
    logic       unused_ins;

    assign opc        = ins_in[15:9];
    assign unused_ins = ^ins_in[8:0];
    assign is_load    = (opc == OP_LD)  || (opc == OP_IOR);
    assign is_store   = (opc == OP_ST)  || (opc == OP_IOW);
    assign is_io      = (opc == OP_IOR) || (opc == OP_IOW);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= RST;
        else        state <= next_state;
    end

    always_comb begin
        ctrl       = CTRL_DEFAULT;
        next_state = state;
        wait_inc   = 1'b0;
        mul_inc    = 1'b0;
        xl_inc     = 1'b0;
        case (state)
            RST: next_state = INF;
            INF: begin
                ctrl.mm      = 1'b1;
                ctrl.mem_req = 1'b1;
                if (mem_rdy_in) begin
                    ctrl.il    = 1'b1;
                    next_state = EX0;
                end else begin
                    wait_inc = 1'b1;
                    if (wait_hit) next_state = ERR;
                end
            end
            EX0: begin
                if (opc[6:4] == 3'b000) begin
                    ctrl.ps    = PS_INC;
                    ctrl.rw    = 1'b1;
                    ctrl.fs    = opc[3:0];
                    next_state = INF;
                end else begin
                    case (opc)
                        OP_LDI, OP_ADI: begin
                            ctrl.ps    = PS_INC;
                            ctrl.rw    = 1'b1;
                            ctrl.mb    = 1'b1;
                            ctrl.fs    = (opc == OP_LDI) ? FS_MOVB : FS_ADD;
                            next_state = INF;
                        end
                        OP_MUL: begin
                            ctrl.fs = FS_MUL;
                            if (MUL_LAT == 1) begin
                                ctrl.ps    = PS_INC;
                                ctrl.rw    = 1'b1;
                                next_state = INF;
                            end else begin
                                mul_inc    = 1'b1;
                                next_state = MW;
                            end
                        end
                        OP_LD, OP_ST, OP_IOR, OP_IOW: begin
                            ctrl.mem_req = 1'b1;
                            ctrl.iom     = is_io;
                            ctrl.wen     = ~is_store;
                            ctrl.md      = (opc == OP_LD) ? MD_MEM : (opc == OP_IOR) ? MD_IO : MD_FU;
                            if (mem_rdy_in) begin
                                ctrl.ps    = PS_INC;
                                ctrl.rw    = is_load;
                                next_state = INF;
                            end else begin
                                wait_inc = 1'b1;
                                if (wait_hit) next_state = ERR;
                            end
                        end
                        OP_BRZ: begin
                            ctrl.ps    = z_in ? PS_BR : PS_INC;
                            next_state = INF;
                        end
                        OP_BRN: begin
                            ctrl.ps    = n_in ? PS_BR : PS_INC;
                            next_state = INF;
                        end
                        OP_JMP: begin
                            ctrl.ps    = PS_JMP;
                            next_state = INF;
                        end
                        OP_XXL: begin
                            if (z_in) begin
                                ctrl.ps    = PS_INC;
                                next_state = INF;
                            end else begin
                                ctrl.fs    = FS_SHL;
                                ctrl.rw    = 1'b1;
                                xl_inc     = 1'b1;
                                next_state = xl_hit ? ERR : XL0;
                            end
                        end
                        OP_HAL:  next_state = HLT;
                        default: next_state = ERR;
                    endcase
                end
            end
            MW: begin
                ctrl.fs = FS_MUL;
                mul_inc = 1'b1;
                if (mul_hit) begin
                    ctrl.rw    = 1'b1;
                    ctrl.ps    = PS_INC;
                    next_state = INF;
                end
            end
            // XL0 returns to EX0 without refetch so XXL re-tests z on the same instruction
            XL0:     next_state = EX0;
            HLT:     next_state = HLT;
            ERR:     next_state = ERR;
            default: next_state = ERR;
        endcase
    end

    assign cnt_clr = ((state == INF) && (next_state == EX0)) ||
                     ((state != INF) && (next_state == INF));

    cu_sat_counter #(.MAX(WAIT_MAX)) u_wait_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(wait_inc), .hit(wait_hit)
    );
    cu_sat_counter #(.MAX(MUL_LAT)) u_mul_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(mul_inc), .hit(mul_hit)
    );
    cu_sat_counter #(.MAX(XL_MAX)) u_xl_cnt (
        .clk(clk), .rst_n(rst_n), .clr(cnt_clr), .inc(xl_inc), .hit(xl_hit)
    );

    assign ps_out      = ctrl.ps;
    assign il_out      = ctrl.il;
    assign rw_out      = ctrl.rw;
    assign rs_out      = '0;
    assign mm_out      = ctrl.mm;
    assign md_out      = ctrl.md;
    assign mb_out      = ctrl.mb;
    assign fs_out      = ctrl.fs;
    assign wen_out     = ctrl.wen;
    assign iom_out     = ctrl.iom;
    assign mem_req_out = ctrl.mem_req;
    assign halted_out  = (state == HLT);
    assign err_out     = (state == ERR);

endmodule

// File: tb/tb_cu_fsm_mc.sv
// tb/tb_cu_fsm_mc.sv - self-checking bench for cu_fsm_mc: directed scenarios plus random trace model
module tb_cu_fsm_mc;
    import mycpu_pkg::*;

    localparam int MUL_LAT = 3, WAIT_MAX = 15, XL_MAX = 16, RA_W = 3;

    logic        clk = 1'b0;
    logic        rst_n, z, n, rdy;
    logic [15:0] ins;
    logic [1:0]  ps_out, md_out;
    logic        il_out, rw_out, mm_out, mb_out, wen_out, iom_out, mem_req_out, halted_out, err_out;
    logic [3:0]  fs_out;
    logic [3*(RA_W+1)-1:0] rs_out;

    int n_run = 0, n_fail = 0;

    typedef struct {
        logic [15:0] ins;
        logic        rdy;
        logic        z;
        logic        n;
        logic [14:0] w;
    } step_t;
    step_t q[$];

    always #5 clk = ~clk;

    cu_fsm_mc #(.MUL_LAT(MUL_LAT), .WAIT_MAX(WAIT_MAX), .XL_MAX(XL_MAX), .RA_W(RA_W)) dut (
        .clk(clk), .rst_n(rst_n), .ins_in(ins), .z_in(z), .n_in(n), .mem_rdy_in(rdy),
        .ps_out(ps_out), .il_out(il_out), .rw_out(rw_out), .rs_out(rs_out), .mm_out(mm_out),
        .md_out(md_out), .mb_out(mb_out), .fs_out(fs_out), .wen_out(wen_out), .iom_out(iom_out),
        .mem_req_out(mem_req_out), .halted_out(halted_out), .err_out(err_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [14:0] wd(input int ps, il, rw, mm, md, mb, fs, wen, iom, req);
        return {2'(ps), 1'(il), 1'(rw), 1'(mm), 2'(md), 1'(mb), 4'(fs), 1'(wen), 1'(iom), 1'(req)};
    endfunction

    function automatic logic [16:0] obs();
        return {halted_out, err_out, ps_out, il_out, rw_out, mm_out, md_out, mb_out, fs_out,
                wen_out, iom_out, mem_req_out};
    endfunction

    task automatic push(input logic [15:0] i, input logic r, input logic zi, input logic ni, input logic [14:0] w);
        step_t s;
        s.ins = i; s.rdy = r; s.z = zi; s.n = ni; s.w = w;
        q.push_back(s);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ins = {OP_MUL, 9'h0}; rdy = 1'b1; z = 1'b0; n = 1'b0;
        tick();
        @(negedge clk);
        n_run++; if ({ps_out, il_out, wen_out, mm_out, mem_req_out} !== 6'b000100) begin n_fail++; $display("FAIL rst_word got %b want %b", {ps_out, il_out, wen_out, mm_out, mem_req_out}, 6'b000100); end
        n_run++; if (rs_out !== 12'h000) begin n_fail++; $display("FAIL rst_rs got %h want 000", rs_out); end
        n_run++; if ({halted_out, err_out} !== 2'b00) begin n_fail++; $display("FAIL rst_flags got %b want 00", {halted_out, err_out}); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_run++; if ({mm_out, mem_req_out} !== 2'b11) begin n_fail++; $display("FAIL rst_inf got %b want 11", {mm_out, mem_req_out}); end
        tick();
        tick();
        @(negedge clk);
        n_run++; if ({fs_out, rw_out} !== 5'b00110) begin n_fail++; $display("FAIL rst_premw got %b want 00110", {fs_out, rw_out}); end
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        n_run++; if ({ps_out, il_out, wen_out, fs_out} !== 8'b00010000) begin n_fail++; $display("FAIL rst_midmul got %b want 00010000", {ps_out, il_out, wen_out, fs_out}); end
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        n_run++; if ({mm_out, mem_req_out, il_out} !== 3'b111) begin n_fail++; $display("FAIL rst_refetch got %b want 111", {mm_out, mem_req_out, il_out}); end
    endtask

    task automatic test_fetch_wait();
        do_reset();
        ins = {OP_JMP, 9'h0};
        for (int i = 0; i < 4; i++) begin
            rdy = (i == 3);
            @(negedge clk);
            n_run++; if ({il_out, ps_out} !== {rdy, 2'b00}) begin n_fail++; $display("FAIL fetch_wait cyc%0d got %b want %b", i, {il_out, ps_out}, {rdy, 2'b00}); end
            tick();
        end
        @(negedge clk);
        n_run++; if (ps_out !== 2'b11) begin n_fail++; $display("FAIL fetch_jmp got %b want 11", ps_out); end
        tick();
    endtask

    task automatic test_mul();
        do_reset();
        ins = {OP_MUL, 9'h1a5}; rdy = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            rdy = 1'($urandom);
            @(negedge clk);
            n_run++; if ({fs_out, rw_out, ps_out} !== {4'b0011, (c == 2), ((c == 2) ? 2'b01 : 2'b00)}) begin n_fail++; $display("FAIL mul cyc%0d got %b want %b", c, {fs_out, rw_out, ps_out}, {4'b0011, (c == 2), ((c == 2) ? 2'b01 : 2'b00)}); end
            tick();
        end
        @(negedge clk);
        n_run++; if (mm_out !== 1'b1) begin n_fail++; $display("FAIL mul_back_inf got %b want 1", mm_out); end
    endtask

    task automatic test_store();
        do_reset();
        ins = {OP_ST, 9'h033}; rdy = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            rdy = (c == 2);
            @(negedge clk);
            n_run++; if ({wen_out, mem_req_out, rw_out, mb_out, ps_out} !== {4'b0100, ((c == 2) ? 2'b01 : 2'b00)}) begin n_fail++; $display("FAIL store cyc%0d got %b want %b", c, {wen_out, mem_req_out, rw_out, mb_out, ps_out}, {4'b0100, ((c == 2) ? 2'b01 : 2'b00)}); end
            tick();
        end
    endtask

    task automatic test_branch();
        logic [6:0] op_t[5];
        logic [1:0] zn_t[5];
        logic [1:0] ps_t[5];
        op_t = '{OP_BRZ, OP_BRZ, OP_BRN, OP_BRN, OP_JMP};
        zn_t = '{2'b10, 2'b01, 2'b00, 2'b01, 2'b00};
        ps_t = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b11};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ins = {op_t[i], 9'($urandom)}; z = zn_t[i][1]; n = zn_t[i][0]; rdy = 1'b1;
            tick();
            @(negedge clk);
            n_run++; if ({ps_out, rw_out, fs_out} !== {ps_t[i], 5'b00000}) begin n_fail++; $display("FAIL branch%0d got %b want %b", i, {ps_out, rw_out, fs_out}, {ps_t[i], 5'b00000}); end
            tick();
        end
    endtask

    task automatic test_halt();
        do_reset();
        ins = {OP_HAL, 9'h0}; rdy = 1'b1;
        tick();
        tick();
        for (int c = 0; c < 10; c++) begin
            ins = 16'($urandom); rdy = 1'($urandom);
            @(negedge clk);
            n_run++; if ({halted_out, err_out, ps_out, mem_req_out, wen_out} !== 6'b100001) begin n_fail++; $display("FAIL halt cyc%0d got %b want 100001", c, {halted_out, err_out, ps_out, mem_req_out, wen_out}); end
            tick();
        end
    endtask

    task automatic test_wait_timeout();
        do_reset();
        ins = {OP_JMP, 9'h0};
        for (int c = 0; c < WAIT_MAX; c++) begin
            rdy = (c == WAIT_MAX - 1);
            @(negedge clk);
            if (c == WAIT_MAX - 1) begin
                n_run++; if ({il_out, err_out} !== 2'b10) begin n_fail++; $display("FAIL wait_edge got %b want 10", {il_out, err_out}); end
            end
            tick();
        end
        tick();
        rdy = 1'b0;
        for (int c = 0; c < WAIT_MAX; c++) begin
            @(negedge clk);
            n_run++; if ({il_out, err_out} !== 2'b00) begin n_fail++; $display("FAIL wait_low cyc%0d got %b want 00", c, {il_out, err_out}); end
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            rdy = 1'($urandom); ins = 16'($urandom);
            @(negedge clk);
            n_run++; if ({err_out, il_out, ps_out, rw_out} !== 5'b10000) begin n_fail++; $display("FAIL wait_err cyc%0d got %b want 10000", c, {err_out, il_out, ps_out, rw_out}); end
            tick();
        end
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        n_run++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err_out); end
        rst_n = 1'b1;
    endtask

    task automatic test_xl_timeout();
        do_reset();
        ins = {OP_XXL, 9'h0}; rdy = 1'b1; z = 1'b0;
        tick();
        for (int it = 0; it < XL_MAX; it++) begin
            @(negedge clk);
            n_run++; if ({rw_out, fs_out, err_out} !== 6'b111100) begin n_fail++; $display("FAIL xl_iter%0d got %b want 111100", it, {rw_out, fs_out, err_out}); end
            tick();
            if (it < XL_MAX - 1) tick();
        end
        @(negedge clk);
        n_run++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL xl_err got %b want 1", err_out); end
        do_reset();
        ins = {7'h7f, 9'h0};
        tick();
        tick();
        @(negedge clk);
        n_run++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL undef_err got %b want 1", err_out); end
    endtask

    task automatic test_random();
        logic [6:0]  others[11];
        logic [6:0]  op;
        logic [15:0] iw;
        logic        zz, nn;
        int          sel, wf, wm, k, ld, wr, io, md;
        others = '{OP_LDI, OP_ADI, OP_LD, OP_ST, OP_IOR, OP_IOW, OP_BRZ, OP_BRN, OP_JMP, OP_MUL, OP_XXL};
        q.delete();
        z = 1'b0; n = 1'b0;
        do_reset();
        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(0, 26);
            op  = (sel < 16) ? 7'(sel) : others[sel - 16];
            iw  = {op, 9'($urandom)};
            zz  = 1'($urandom);
            nn  = 1'($urandom);
            wf  = $urandom_range(0, 4);
            for (int i = 0; i < wf; i++) push(iw, 1'b0, 1'($urandom), 1'($urandom), wd(0, 0, 0, 1, 0, 0, 0, 1, 0, 1));
            push(iw, 1'b1, 1'($urandom), 1'($urandom), wd(0, 1, 0, 1, 0, 0, 0, 1, 0, 1));
            if (sel < 16) begin
                push(iw, 1'($urandom), zz, nn, wd(1, 0, 1, 0, 0, 0, int'(op[3:0]), 1, 0, 0));
            end else if (op == OP_LDI || op == OP_ADI) begin
                push(iw, 1'($urandom), zz, nn, wd(1, 0, 1, 0, 0, 1, (op == OP_LDI) ? 12 : 2, 1, 0, 0));
            end else if (op == OP_MUL) begin
                for (int i = 0; i < MUL_LAT - 1; i++) push(iw, 1'($urandom), zz, nn, wd(0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
                push(iw, 1'($urandom), zz, nn, wd(1, 0, 1, 0, 0, 0, 3, 1, 0, 0));
            end else if (op == OP_BRZ || op == OP_BRN || op == OP_JMP) begin
                push(iw, 1'($urandom), zz, nn, wd((op == OP_JMP) ? 3 : (((op == OP_BRZ) ? zz : nn) ? 2 : 1), 0, 0, 0, 0, 0, 0, 1, 0, 0));
            end else if (op == OP_XXL) begin
                k = $urandom_range(0, 3);
                for (int i = 0; i < k; i++) begin
                    push(iw, 1'($urandom), 1'b0, nn, wd(0, 0, 1, 0, 0, 0, 14, 1, 0, 0));
                    push(iw, 1'($urandom), 1'($urandom), nn, wd(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
                end
                push(iw, 1'($urandom), 1'b1, nn, wd(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
            end else begin
                ld = (op == OP_LD || op == OP_IOR) ? 1 : 0;
                wr = (op == OP_ST || op == OP_IOW) ? 1 : 0;
                io = (op == OP_IOR || op == OP_IOW) ? 1 : 0;
                md = (op == OP_LD) ? 1 : (op == OP_IOR) ? 2 : 0;
                wm = $urandom_range(0, 4);
                for (int i = 0; i < wm; i++) push(iw, 1'b0, zz, nn, wd(0, 0, 0, 0, md, 0, 0, 1 - wr, io, 1));
                push(iw, 1'b1, zz, nn, wd(1, 0, ld, 0, md, 0, 0, 1 - wr, io, 1));
            end
        end
        foreach (q[j]) begin
            ins = q[j].ins; rdy = q[j].rdy; z = q[j].z; n = q[j].n;
            @(negedge clk);
            n_run++; if (obs() !== {2'b00, q[j].w}) begin n_fail++; $display("FAIL rand step%0d ins %h got %h want %h", j, q[j].ins, obs(), {2'b00, q[j].w}); end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fetch_wait();
        test_mul();
        test_store();
        test_branch();
        test_halt();
        test_wait_timeout();
        test_xl_timeout();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
